// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared FSM encoding and counter-width helper for cla_seq_adder
//
// Purpose : state type used by the controller, plus the index-counter width helper.
// Contents: state_t (S_IDLE=0, S_RUN=1, S_DONE=2; 2'd3 is illegal and decodes as IDLE),
//           idx_width(n) = ceil(log2(n)), never less than 1.
package cla_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter width for n chunks; a single-chunk adder still gets a 1-bit index.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/cla_chunk_add.sv
// rtl/cla_chunk_add.sv - combinational CHUNK-bit carry-lookahead slice
//
// Purpose : CHUNK-bit adder built from 4-bit generate/propagate lookahead groups,
//           with the group carries rippled from one group to the next.
// Ports   : a, b  [CHUNK-1:0] addends
//           cin   carry into bit 0
//           sum   [CHUNK-1:0] a + b + cin (modulo 2^CHUNK)
//           cout  carry out of bit CHUNK-1
module cla_chunk_add
    import cla_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    localparam int NG = CHUNK / 4;

    // w_gc[g] is the carry entering group g.
    logic [NG:0] w_gc;

    assign w_gc[0] = cin;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        logic [3:0] w_p;
        logic [3:0] w_g;
        logic [4:0] w_c;

        assign w_p = a[gi*4 +: 4] ^ b[gi*4 +: 4];
        assign w_g = a[gi*4 +: 4] & b[gi*4 +: 4];

        // Every carry inside the group is a flat two-level function of the
        // group's generate/propagate bits and the incoming group carry.
        assign w_c[0] = w_gc[gi];
        assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
        assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
        assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                      | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
        assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                      | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                      | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

        assign sum[gi*4 +: 4] = w_p ^ w_c[3:0];
        assign w_gc[gi+1]     = w_c[4];
    end

    assign cout = w_gc[NG];

endmodule

// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle adder/subtractor reusing one CHUNK-wide lookahead slice
//
// Purpose : computes a+b+cin or a-b, CHUNK bits per clock, with a registered carry
//           between chunks and valid/ready handshakes on both sides.
// Ports   : clk, rst (async, active high)
//           in_valid/in_ready, a, b, cin, sub      operand side (in_ready only in IDLE)
//           out_valid/out_ready, sum, cout, overflow  result side (all registered)
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_overflow;
    logic             r_out_valid;

    logic [CHUNK-1:0] w_chunk_a;
    logic [CHUNK-1:0] w_chunk_b;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_cout;
    logic             w_carry_into_msb;
    logic             w_idle;

    // The unused encoding 2'd3 behaves exactly like IDLE.
    assign w_idle   = (r_state != S_RUN) && (r_state != S_DONE);
    assign in_ready = w_idle;

    assign w_chunk_a = r_op_a[int'(r_idx) * CHUNK +: CHUNK];
    assign w_chunk_b = r_op_b[int'(r_idx) * CHUNK +: CHUNK];

    cla_chunk_add #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a    (w_chunk_a),
        .b    (w_chunk_b),
        .cin  (r_carry),
        .sum  (w_chunk_sum),
        .cout (w_chunk_cout)
    );

    // Recover the carry into the MSB from the MSB's own sum bit; only
    // meaningful while the final chunk is in the slice.
    assign w_carry_into_msb = r_op_a[WIDTH-1] ^ r_op_b[WIDTH-1] ^ w_chunk_sum[CHUNK-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_sum[int'(r_idx) * CHUNK +: CHUNK] <= w_chunk_sum;
                    r_carry <= w_chunk_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout      <= w_chunk_cout;
                        r_overflow  <= w_carry_into_msb ^ w_chunk_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1.
                        r_op_a  <= a;
                        r_op_b  <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_state <= S_RUN;
                    end
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - directed self-checking bench for cla_seq_adder (WIDTH=32, CHUNK=8)
module tb_cla_seq_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;

    int n_checks;
    int n_fail;

    cla_seq_adder #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one operand set for a single cycle; returns at the negedge after the accept edge.
    task automatic start_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                            input logic tc, input logic ts);
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a = ta;
        b = tb_v;
        cin = tc;
        sub = ts;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic tc, input logic ts, input logic [31:0] e_sum,
                          input logic e_cout, input logic e_ov);
        int lat;
        start_op(tag, ta, tb_v, tc, ts);
        chk({tag, "_busy"}, 64'(in_ready), 64'd0);
        wait_done(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_sum"}, 64'(sum), 64'(e_sum));
        chk({tag, "_cout"}, 64'(cout), 64'(e_cout));
        chk({tag, "_ovf"}, 64'(overflow), 64'(e_ov));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;

        run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("sub_brw",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("add_cin",  32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run_op("sub_pos",  32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        run_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Result held in DONE while the producer keeps offering a new operand.
        start_op("hold", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        wait_done(lat);
        chk("hold_latency", 64'(lat), 64'd4);
        a = 32'h0000_0001;
        b = 32'h0000_0002;
        cin = 1'b0;
        sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_sum", 64'(sum), 64'h30);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold_release_ov", 64'(out_valid), 64'd0);
        chk("hold_release_rdy", 64'(in_ready), 64'd1);
        chk("hold_release_sum", 64'(sum), 64'h30);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_next_busy", 64'(in_ready), 64'd0);
        wait_done(lat);
        chk("hold_next_latency", 64'(lat), 64'd4);
        chk("hold_next_sum", 64'(sum), 64'h3);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset mid-RUN; cout/overflow are still 1 from this setup op.
        run_op("pre_rst", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        start_op("mid_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_cout", 64'(cout), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        run_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
